// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: fetch/decode/execute sequencer driving the 20-bit ALU datapath controls.
// Define ALU_CTRL_TIMEOUT_EN to add the handshake watchdog and its timeout_err port.
module alu_ctrl_seq #(
    parameter int         PC_W   = 8,
    parameter logic [3:0] DR_SEL = 4'hF
`ifdef ALU_CTRL_TIMEOUT_EN
    ,
    parameter int         TIMEOUT_CYC = 255
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [11:0]     imem_data,
    output logic [PC_W-1:0] pc,
    output logic [3:0]      alu_op,
    output logic [3:0]      bus_sel,
    output logic            ac_load,
    output logic            reg_wr,
    output logic [3:0]      reg_wr_sel,
    input  logic            alu_z,
    input  logic            alu_n,
    output logic            dmem_rd,
    output logic            dmem_wr,
    input  logic            dmem_ack,
    output logic            z_flag,
    output logic            n_flag,
    output logic            illegal,
    output logic            halted,
    output logic [2:0]      dbgState
`ifdef ALU_CTRL_TIMEOUT_EN
    ,
    output logic            timeout_err
`endif
);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM_WAIT, HALT} stateE;

    localparam logic [3:0] OP_ALU      = 4'h1;
    localparam logic [3:0] OP_MVAC     = 4'h2;
    localparam logic [3:0] OP_LOAD     = 4'h3;
    localparam logic [3:0] OP_STORE    = 4'h4;
    localparam logic [3:0] OP_JMP      = 4'h5;
    localparam logic [3:0] OP_JMPZ     = 4'h6;
    localparam logic [3:0] OP_JMPN     = 4'h7;
    localparam logic [3:0] OP_HALT     = 4'h8;
    localparam logic [3:0] OP_ILL_BASE = 4'h9;
    localparam logic [3:0] ALU_PASS_AC = 4'h1;
    localparam logic [3:0] ALU_PASS_DR = 4'h0;

    stateE            state, stateNext;
    logic [11:0]      ir, irNext;
    logic [PC_W-1:0]  pcNext, jumpTarget;
    logic [3:0]       opcode, fieldA, fieldB;
    logic [3:0]       aluOpNext, busSelNext, regWrSelNext;
    logic             zNext, nNext, imemReqNext, acLoadNext, regWrNext;
    logic             dmemRdNext, dmemWrNext, illegalNext;
    logic             imemDone, dmemDone;

    assign opcode     = ir[11:8];
    assign fieldA     = ir[7:4];
    assign fieldB     = ir[3:0];
    assign jumpTarget = PC_W'(ir[7:0]);
    assign dbgState   = state;

    // Handshake: a request stays asserted until an ack is sampled while it is high;
    // an ack seen while the matching request is low is dropped.
    assign imemDone = imem_req && imem_ack;
    assign dmemDone = (dmem_rd || dmem_wr) && dmem_ack;

`ifdef ALU_CTRL_TIMEOUT_EN
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] wdog, wdogNext;
    logic       timeoutNext, waiting;
    assign waiting = (state == FETCH && !imemDone) || (state == MEM_WAIT && !dmemDone);
`endif

    always_comb begin
        stateNext    = state;
        irNext       = ir;
        pcNext       = pc;
        zNext        = z_flag;
        nNext        = n_flag;
        aluOpNext    = alu_op;
        busSelNext   = bus_sel;
        regWrSelNext = reg_wr_sel;
        acLoadNext   = 1'b0;
        regWrNext    = 1'b0;
        dmemRdNext   = 1'b0;
        dmemWrNext   = 1'b0;
        illegalNext  = 1'b0;
        if (ac_load) begin
            zNext = alu_z;
            nNext = alu_n;
        end
        case (state)
            FETCH: begin
                if (imemDone) begin
                    irNext    = imem_data;
                    pcNext    = pc + PC_W'(1);
                    stateNext = DECODE;
                end
            end
            DECODE: begin
                stateNext = EXEC;
                case (opcode)
                    OP_ALU: begin
                        aluOpNext  = fieldA;
                        busSelNext = fieldB;
                        acLoadNext = 1'b1;
                    end
                    OP_MVAC: begin
                        aluOpNext    = ALU_PASS_AC;
                        regWrSelNext = fieldB;
                        regWrNext    = 1'b1;
                    end
                    OP_LOAD:  dmemRdNext = 1'b1;
                    OP_STORE: dmemWrNext = 1'b1;
                    default:  illegalNext = (opcode >= OP_ILL_BASE);
                endcase
            end
            EXEC, MEM_WAIT: begin
                stateNext = FETCH;
                case (opcode)
                    OP_LOAD, OP_STORE: begin
                        if (dmemDone) begin
                            // Load data lands in AC the cycle after the ack.
                            if (opcode == OP_LOAD) begin
                                aluOpNext  = ALU_PASS_DR;
                                busSelNext = DR_SEL;
                                acLoadNext = 1'b1;
                            end
                        end else begin
                            stateNext  = MEM_WAIT;
                            dmemRdNext = dmem_rd;
                            dmemWrNext = dmem_wr;
                        end
                    end
                    OP_JMP:  pcNext = jumpTarget;
                    OP_JMPZ: if (z_flag) pcNext = jumpTarget;
                    OP_JMPN: if (n_flag) pcNext = jumpTarget;
                    OP_HALT: stateNext = HALT;
                    default: ;
                endcase
            end
            HALT:    stateNext = HALT;
            default: stateNext = FETCH;
        endcase
`ifdef ALU_CTRL_TIMEOUT_EN
        wdogNext    = waiting ? wdog + 8'd1 : 8'd0;
        timeoutNext = timeout_err;
        if (waiting && wdog == WDOG_LAST) begin
            stateNext   = HALT;
            dmemRdNext  = 1'b0;
            dmemWrNext  = 1'b0;
            wdogNext    = 8'd0;
            timeoutNext = 1'b1;
        end
`endif
        imemReqNext = (stateNext == FETCH);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= FETCH;
            ir         <= 12'h000;
            pc         <= '0;
            z_flag     <= 1'b0;
            n_flag     <= 1'b0;
            imem_req   <= 1'b0;
            alu_op     <= ALU_PASS_AC;
            bus_sel    <= 4'h0;
            ac_load    <= 1'b0;
            reg_wr     <= 1'b0;
            reg_wr_sel <= 4'h0;
            dmem_rd    <= 1'b0;
            dmem_wr    <= 1'b0;
            illegal    <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state      <= stateNext;
            ir         <= irNext;
            pc         <= pcNext;
            z_flag     <= zNext;
            n_flag     <= nNext;
            imem_req   <= imemReqNext;
            alu_op     <= aluOpNext;
            bus_sel    <= busSelNext;
            ac_load    <= acLoadNext;
            reg_wr     <= regWrNext;
            reg_wr_sel <= regWrSelNext;
            dmem_rd    <= dmemRdNext;
            dmem_wr    <= dmemWrNext;
            illegal    <= illegalNext;
            halted     <= (stateNext == HALT);
        end
    end

`ifdef ALU_CTRL_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdog        <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            wdog        <= wdogNext;
            timeout_err <= timeoutNext;
        end
    end
`endif

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Multi-cycle control sequencer on the controlling end of the 20-bit datapath ALU interface.
- Fetches 12-bit instructions over a req/ack instruction port and decodes them.
- Drives the 4-bit ALU ControlSignal, register-bus source select, AC/register loads, PC and data-memory handshakes.
- Consumes the ALU Z/N outputs, latching them as flags for conditional jumps.

Parameters:
- PC_W, 8, program counter / jump target width.
- DR_SEL, 4'hF, bus_sel code selecting the memory data register onto InputBus.
- TIMEOUT_CYC, 255, handshake watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  instruction valid, one-cycle pulse
- imem_data  in  12  instruction word: [11:8] opcode, [7:4] A, [3:0] B
- pc  out  PC_W  current instruction address
- alu_op  out  4  drives ALU ControlSignal
- bus_sel  out  4  register-file source select onto ALU InputBus
- ac_load  out  1  AC <= ALU OutputBus this cycle
- reg_wr  out  1  register[reg_wr_sel] <= ALU OutputBus
- reg_wr_sel  out  4  destination register index
- alu_z  in  1  ALU Z output
- alu_n  in  1  ALU N output
- dmem_rd  out  1  data read request, held until ack
- dmem_wr  out  1  data write request, held until ack
- dmem_ack  in  1  data transfer complete, one-cycle pulse
- z_flag  out  1  latched zero flag
- n_flag  out  1  latched negative flag
- illegal  out  1  one-cycle pulse on undefined opcode
- halted  out  1  high in HALT state

Behaviour:
- Reset (rst_n low at a clk edge, any state): state=FETCH, pc=0, IR=0, z_flag=0, n_flag=0.
- Reset drives all strobes (imem_req, ac_load, reg_wr, dmem_rd, dmem_wr, illegal) to 0, halted=0, alu_op=4'h1 (pass AC), bus_sel=0, reg_wr_sel=0.
- Reset mid-handshake drops requests the next cycle; acks arriving afterward are ignored.
- All outputs are registered or decoded purely from state and IR; no combinational path from any input to any output.
- States: FETCH, DECODE, EXEC, MEM_WAIT, HALT.
- FETCH: imem_req=1 until imem_ack. On ack: IR<=imem_data, pc<=pc+1 (wraps modulo 2^PC_W), go to DECODE.
- DECODE: one cycle. Registers alu_op/bus_sel/reg_wr_sel from IR, then goes to EXEC.
- EXEC by opcode (single cycle unless noted), then FETCH:
  - 0x0 NOP: no strobes.
  - 0x1 ALU: alu_op=A, bus_sel=B, ac_load=1; z_flag<=alu_z, n_flag<=alu_n same edge.
  - 0x2 MVAC: alu_op=4'h1, reg_wr=1, reg_wr_sel=B; flags unchanged.
  - 0x3 LOAD: dmem_rd=1, go to MEM_WAIT. On dmem_ack: alu_op=4'h0, bus_sel=DR_SEL, ac_load=1, flags latched, then FETCH.
  - 0x4 STORE: dmem_wr=1, go to MEM_WAIT. On dmem_ack, go to FETCH.
  - 0x5 JMP: pc<={A,B} (zero-extended/truncated to PC_W).
  - 0x6 JMPZ: jump if z_flag=1, else fall through.
  - 0x7 JMPN: jump if n_flag=1, else fall through.
  - 0x8 HALT: go to HALT; halted=1. Leaves HALT only by reset.
  - 0x9-0xF: illegal=1 for one cycle, executes as NOP.
- Conditional jumps test the flag value before any update in the same cycle.
- Flags update only on ac_load cycles.
- An ack that arrives in a cycle with no outstanding request is ignored.
- An ack on the same edge the request first asserts completes the transfer.
- Latency: ALU instruction takes 3 cycles with zero-wait fetch (FETCH 1, DECODE 1, EXEC 1). LOAD/STORE take 3 cycles plus memory wait.

Optional Feature:
- Macro: ALU_CTRL_TIMEOUT_EN.
- Defined: an 8-bit watchdog counts cycles while in FETCH or MEM_WAIT without ack. It clears on ack or state exit. When it reaches TIMEOUT_CYC, the sequencer drops requests, enters HALT, and raises output port timeout_err (1 bit, sticky until reset).
- Undefined: no counter, no timeout_err port; handshakes wait indefinitely.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles mid-LOAD -> next cycle dmem_rd=0, pc=0, state FETCH, imem_req=1, z_flag=0, n_flag=0.
- ALU op: fetch 0x124 with alu_z=0, alu_n=1 -> in EXEC: alu_op=2, bus_sel=4, ac_load=1 for exactly one cycle; n_flag=1, z_flag=0; next imem_req with pc=1.
- LOAD with wait: fetch 0x300, dmem_ack after 5 cycles -> dmem_rd high 5 cycles, then alu_op=0, bus_sel=4'hF, ac_load=1 for one cycle.
- Branches: z_flag=1, fetch 0x63C -> pc=0x3C. z_flag=0, same instruction -> pc increments only.
- PC wrap and illegal: pc=0xFF, fetch 0xA00 -> pc=0x00, illegal pulses once, no other strobes.
- HALT then timeout (macro on, TIMEOUT_CYC=10): 0x800 -> halted=1 permanently. Separately, withhold imem_ack -> timeout_err=1 after 10 cycles, imem_req=0.
